// File: rtl/simmem_axi_wr_responder.sv
// AXI4 write-channel responder: queues AW bursts in order, consumes the matching
// W beats, and returns one B per burst (SLVERR for illegal bursts or WLAST errors).
module simmem_axi_wr_responder #(
  parameter int IDWidth          = 2,
  parameter int AxLenWidth       = 8,
  parameter int AxBurstWidth     = 2,
  parameter int XRespWidth       = 3,
  parameter int MaxBurstLenField = 2,
  parameter int AwFifoDepth      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [IDWidth-1:0]      aw_id_i,
  input  logic [AxLenWidth-1:0]   aw_len_i,
  input  logic [AxBurstWidth-1:0] aw_burst_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic                    w_last_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [IDWidth-1:0]      b_id_o,
  output logic [XRespWidth-1:0]   b_resp_o,
  output logic [1:0]              dbg_state_o
);

  // Handshake rule on every channel: a transfer happens on the rising clock
  // edge where valid and ready are both high; valid never waits on ready.

  localparam int PtrW = $clog2(AwFifoDepth);
  localparam logic [AxLenWidth-1:0] MaxLen    = AxLenWidth'((1 << MaxBurstLenField) - 1);
  localparam logic [XRespWidth-1:0] RespOkay  = '0;
  localparam logic [XRespWidth-1:0] RespSlverr = XRespWidth'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [IDWidth-1:0]    id_mem  [AwFifoDepth];
  logic [AxLenWidth-1:0] len_mem [AwFifoDepth];
  logic [AwFifoDepth-1:0] bad_mem;
  logic [PtrW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [PtrW:0]   count;

  logic full, push, pop, push_bad, w_hs, len_hit, beat_end, end_err;
  logic load_next, head_bad_next;
  logic [AxLenWidth-1:0] beat_cnt;
  logic err;

  assign full       = (count == (PtrW+1)'(AwFifoDepth));
  assign aw_ready_o = !full;
  assign push       = aw_valid_i && !full;
  assign push_bad   = (aw_burst_i == AxBurstWidth'(3)) || (aw_len_i > MaxLen);
  assign pop        = b_valid_o && b_ready_i;
  assign rd_ptr_nxt = rd_ptr + PtrW'(1);

  assign w_ready_o = (state == DATA);
  assign w_hs      = w_valid_i && w_ready_o;
  assign len_hit   = (beat_cnt == len_mem[rd_ptr]);
  assign beat_end  = w_last_i || len_hit;
  assign end_err   = err || (w_last_i != len_hit);

  // A pushed entry lands exactly at rd_ptr_nxt when only the popped head remains.
  assign load_next     = pop && ((count > (PtrW+1)'(1)) || push);
  assign head_bad_next = (count > (PtrW+1)'(1)) ? bad_mem[rd_ptr_nxt] : push_bad;

  assign dbg_state_o = state;

  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem[wr_ptr]  <= aw_id_i;
      len_mem[wr_ptr] <= aw_len_i;
      bad_mem[wr_ptr] <= push_bad;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      count <= count + (PtrW+1)'(push) - (PtrW+1)'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0) state_next = DATA;
      DATA:    if (w_hs && beat_end) state_next = RSP;
      RSP:     if (pop) state_next = load_next ? DATA : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt  <= '0;
      err       <= 1'b0;
      b_valid_o <= 1'b0;
      b_id_o    <= '0;
      b_resp_o  <= '0;
    end else begin
      if (state == IDLE && count != '0) begin
        beat_cnt <= '0;
        err      <= bad_mem[rd_ptr];
      end
      if (w_hs) begin
        if (beat_end) begin
          b_valid_o <= 1'b1;
          b_id_o    <= id_mem[rd_ptr];
          b_resp_o  <= end_err ? RespSlverr : RespOkay;
        end else begin
          beat_cnt <= beat_cnt + AxLenWidth'(1);
        end
      end
      if (pop) begin
        b_valid_o <= 1'b0;
        if (load_next) begin
          beat_cnt <= '0;
          err      <= head_bad_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_simmem_axi_wr_responder.sv
// Randomised scoreboard bench for simmem_axi_wr_responder: expected B responses
// are computed per burst from the AXI rules and popped by an independent monitor.
module tb_simmem_axi_wr_responder;

  localparam int IDW = 2;
  localparam int LW  = 8;
  localparam int BW  = 2;
  localparam int RW  = 3;
  localparam int EW  = IDW + RW;

  logic clk = 1'b0;
  logic rst_ni;
  logic aw_valid_i, aw_ready_o;
  logic [IDW-1:0] aw_id_i;
  logic [LW-1:0]  aw_len_i;
  logic [BW-1:0]  aw_burst_i;
  logic w_valid_i, w_ready_o, w_last_i;
  logic b_valid_o, b_ready_i;
  logic [IDW-1:0] b_id_o;
  logic [RW-1:0]  b_resp_o;
  logic [1:0]     dbg_state;

  simmem_axi_wr_responder dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
    .aw_len_i(aw_len_i), .aw_burst_i(aw_burst_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];
  logic [1:0]    wbeat_q[$];   // {final beat of burst, w_last value}
  int exp_beats = 0;
  int w_hs_cnt  = 0;
  bit w_en = 1'b0;
  int b_mode = 0;              // 0 hold low, 1 hold high, 2 random
  logic cur_end = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int model_beats(input int len, input int last_pos);
    return (last_pos >= 1 && last_pos <= len + 1) ? last_pos : len + 1;
  endfunction

  function automatic logic [RW-1:0] model_resp(input int len, input int burst, input int last_pos);
    bit bad;
    bad = (burst == 3) || (len >= 4);
    return (bad || last_pos != len + 1) ? RW'(2) : RW'(0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_aw(input int id, input int len, input int burst, input int last_pos,
                         input bit expect_b);
    int nb, n;
    if (expect_b) begin
      nb = model_beats(len, last_pos);
      for (int i = 1; i <= nb; i++) wbeat_q.push_back({i == nb, i == last_pos});
      exp_q.push_back({IDW'(id), model_resp(len, burst, last_pos)});
      exp_beats += nb;
    end
    aw_valid_i = 1'b1;
    aw_id_i    = IDW'(id);
    aw_len_i   = LW'(len);
    aw_burst_i = BW'(burst);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!aw_ready_o && n < 500);
    check("aw_accept", aw_ready_o, 1);
    @(posedge clk);
    #1;
    aw_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || wbeat_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", t < 3000, 1);
    repeat (4) @(negedge clk);
    check("w_beat_total", w_hs_cnt, exp_beats);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_aw_ready"}, aw_ready_o, 1);
    check({tag, "_w_ready"},  w_ready_o, 0);
    check({tag, "_b_valid"},  b_valid_o, 0);
    check({tag, "_b_id"},     b_id_o, 0);
    check({tag, "_b_resp"},   b_resp_o, 0);
  endtask

  // W beat driver: one beat per wbeat_q entry, random idle cycles in between.
  initial begin
    int n;
    w_valid_i = 1'b0;
    w_last_i  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (w_en && wbeat_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        w_valid_i = 1'b1;
        w_last_i  = wbeat_q[0][0];
        cur_end   = wbeat_q[0][1];
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!w_ready_o && n < 3000);
        if (w_ready_o) void'(wbeat_q.pop_front());
        else begin
          check("w_hs_timeout", w_ready_o, 1);
          wbeat_q.delete();
        end
      end else begin
        w_valid_i = 1'b0;
        w_last_i  = 1'b0;
        cur_end   = 1'b0;
      end
    end
  end

  initial begin
    b_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (b_mode)
        0:       b_ready_i = 1'b0;
        1:       b_ready_i = 1'b1;
        default: b_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic b_prev = 1'b0;
  logic end_hs_prev = 1'b0;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst_ni) begin
      b_prev      = 1'b0;
      end_hs_prev = 1'b0;
    end else begin
      if (b_valid_o && !b_prev) check("b_after_final_beat", end_hs_prev, 1);
      if (b_valid_o && b_ready_i) begin
        check("b_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("b_id", b_id_o, e[EW-1:RW]);
          check("b_resp", b_resp_o, e[RW-1:0]);
        end
      end
      if (w_valid_i && w_ready_o) begin
        w_hs_cnt++;
        end_hs_prev = cur_end;
      end else begin
        end_hs_prev = 1'b0;
      end
      b_prev = b_valid_o;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int n, len, burst, last_pos;
    rst_ni = 1'b0;
    aw_valid_i = 1'b0;
    aw_id_i = '0;
    aw_len_i = '0;
    aw_burst_i = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    b_mode = 1;
    w_en   = 1'b1;

    // single INCR burst and AW-to-w_ready latency
    send_aw(1, 3, 1, 4, 1);
    @(negedge clk);
    check("aw_to_wready_t1", w_ready_o, 0);
    @(negedge clk);
    check("aw_to_wready_t2", w_ready_o, 1);
    drain();

    // early / missing last and illegal bursts
    send_aw(1, 2, 1, 2, 1);
    send_aw(2, 1, 1, 0, 1);
    send_aw(3, 1, 1, 2, 1);
    send_aw(0, 0, 3, 1, 1);
    send_aw(1, 4, 1, 5, 1);
    drain();

    // queue full with W and B stalled
    w_en   = 1'b0;
    b_mode = 0;
    for (int i = 0; i < 4; i++) send_aw(i, 0, 1, 1, 1);
    @(negedge clk);
    check("aw_full", aw_ready_o, 0);
    @(posedge clk);
    #1;
    fork
      send_aw(4, 0, 1, 1, 1);
      begin
        repeat (5) @(negedge clk);
        check("aw_held", aw_ready_o, 0);
        w_en   = 1'b1;
        b_mode = 1;
      end
    join
    drain();

    // B stall with another burst queued behind
    b_mode = 0;
    send_aw(3, 1, 1, 2, 1);
    send_aw(1, 0, 0, 1, 1);
    n = 0;
    while (!b_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_stall_seen", b_valid_o, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("b_stall_valid", b_valid_o, 1);
      check("b_stall_id", b_id_o, 3);
      check("b_stall_resp", b_resp_o, 0);
      check("b_stall_wready", w_ready_o, 0);
    end
    b_mode = 1;
    drain();

    // reset after 2 of 4 beats; the aborted burst must never produce a B
    wbeat_q.push_back(2'b00);
    wbeat_q.push_back(2'b00);
    exp_beats += 2;
    send_aw(2, 3, 1, 4, 0);
    n = 0;
    while (wbeat_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("abort_beats_sent", wbeat_q.size(), 0);
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    send_aw(1, 3, 1, 4, 1);
    drain();

    // randomised traffic
    b_mode = 2;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      len      = $urandom_range(0, 5);
      burst    = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      last_pos = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len + 2) : len + 1;
      send_aw($urandom_range(0, 3), len, burst, last_pos, 1);
    end
    b_mode = 1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
